// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the trace sniffer capture path.
//   - default widths for the match sequencer
//   - FSM state encoding for match_capture_sequencer
//   - FIFO word field offsets: {rule index, timestamp}, timestamp in the LSBs
package trace_pkg;

  localparam int DEF_NUM_RULES  = 8;
  localparam int DEF_TS_WIDTH   = 56;
  localparam int DEF_RULE_WIDTH = 8;

  // Timestamp sits at bit 0; the rule index sits directly above it.
  localparam int FIFO_TS_LSB = 0;

  function automatic int fifo_rule_lsb(input int ts_width);
    return FIFO_TS_LSB + ts_width;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rule_prio_enc.sv
// rule_prio_enc: lowest-set-bit priority encoder.
// Ports:
//   i_vec    in   pWIDTH   request vector
//   o_valid  out  1        any bit set
//   o_idx    out  pIDX_W   index of the lowest set bit (0 when none)
//   o_clr    out  pWIDTH   one-hot mask of that bit (0 when none)
module rule_prio_enc #(
  parameter int pWIDTH = 8,
  parameter int pIDX_W = 8
) (
  input  logic [pWIDTH-1:0] i_vec,
  output logic              o_valid,
  output logic [pIDX_W-1:0] o_idx,
  output logic [pWIDTH-1:0] o_clr
);

  assign o_valid = |i_vec;
  // Two's-complement trick isolates the lowest set bit.
  assign o_clr   = i_vec & (~i_vec + pWIDTH'(1));

  // Walk from the top down so the last hit written is the lowest index.
  always_comb begin
    o_idx = '0;
    for (int i = pWIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = pIDX_W'(i);
    end
  end

endmodule

// File: rtl/match_capture_sequencer.sv
// match_capture_sequencer: arms/disarms trace-match capture, timestamps
// per-rule match strobes and serialises them into one {rule, timestamp}
// FIFO word per cycle, lowest rule first. Drives the external trigger in
// pulse or toggle mode. Single clock domain (trace_clk).
// Ports:
//   trace_clk, resetn      clock, async active-low reset
//   I_arm / I_disarm       one-cycle commands (arm wins when both)
//   I_capture_mode         0 single, 1 continuous
//   I_pattern_enable       per-rule enable
//   I_trig_enable          gates O_trig_out events
//   I_trig_toggle          0 pulse, 1 toggle
//   I_match                per-rule match strobes
//   I_fifo_full            sniff FIFO full
//   O_fifo_wr/O_fifo_data  FIFO write strobe / {rule, timestamp}
//   O_trig_out             trigger output
//   O_armed / O_busy       FSM in ARMED / FSM not IDLE
//   O_overflow             sticky dropped-match flag, cleared by I_arm
module match_capture_sequencer
  import trace_pkg::*;
#(
  parameter int pNUM_RULES  = DEF_NUM_RULES,
  parameter int pTS_WIDTH   = DEF_TS_WIDTH,
  parameter int pRULE_WIDTH = DEF_RULE_WIDTH
) (
  input  logic                           trace_clk,
  input  logic                           resetn,
  input  logic                           I_arm,
  input  logic                           I_disarm,
  input  logic                           I_capture_mode,
  input  logic [pNUM_RULES-1:0]          I_pattern_enable,
  input  logic                           I_trig_enable,
  input  logic                           I_trig_toggle,
  input  logic [pNUM_RULES-1:0]          I_match,
  input  logic                           I_fifo_full,
  output logic                           O_fifo_wr,
  output logic [pRULE_WIDTH+pTS_WIDTH-1:0] O_fifo_data,
  output logic                           O_trig_out,
  output logic                           O_armed,
  output logic                           O_busy,
  output logic                           O_overflow
);

  localparam int FIFO_W   = pRULE_WIDTH + pTS_WIDTH;
  localparam int RULE_LSB = fifo_rule_lsb(pTS_WIDTH);

  state_e                  r_state, w_state_nxt;
  logic [pTS_WIDTH-1:0]    r_ts, r_t, w_emit_ts;
  logic [pNUM_RULES-1:0]   r_pend, w_m, w_pend_after, w_cand, w_clr;
  logic [pNUM_RULES-1:0]   w_cand_after, w_pend_nxt;
  logic [pRULE_WIDTH-1:0]  w_idx;
  logic [FIFO_W-1:0]       r_data, w_word;
  logic                    r_wr, r_trig, r_armed, r_busy, r_ovf;
  logic                    w_pend_any, w_hit, w_accept, w_drop, w_emit;
  logic                    w_enc_vld, w_trig_evt, w_trig_nxt;

  assign w_m        = I_match & I_pattern_enable;
  assign w_pend_any = |r_pend;

  // r_pend holds hits not yet written. Its lowest bit leaves this cycle
  // unless the FIFO is full; a new hit is taken only if nothing remains.
  assign w_pend_after = (w_pend_any && !I_fifo_full) ?
                        (r_pend & (r_pend - pNUM_RULES'(1))) : r_pend;
  assign w_hit    = (r_state == ST_ARMED) && (|w_m);
  assign w_accept = w_hit && (w_pend_after == '0);
  assign w_drop   = w_hit && (w_pend_after != '0);

  // With nothing pending, a freshly accepted hit is written straight away
  // (stamped with the current ts) so the first word lands one cycle later.
  assign w_cand    = w_pend_any ? r_pend : (w_accept ? w_m : '0);
  assign w_emit_ts = w_pend_any ? r_t : r_ts;

  rule_prio_enc #(
    .pWIDTH (pNUM_RULES),
    .pIDX_W (pRULE_WIDTH)
  ) u_enc (
    .i_vec   (w_cand),
    .o_valid (w_enc_vld),
    .o_idx   (w_idx),
    .o_clr   (w_clr)
  );

  assign w_emit       = w_enc_vld && !I_fifo_full;
  assign w_cand_after = w_emit ? (w_cand & ~w_clr) : w_cand;
  // Last pending bit leaving while a new hit arrives: the hit replaces it.
  assign w_pend_nxt   = (w_pend_any && w_accept) ? w_m : w_cand_after;

  always_comb begin
    w_word = '0;
    w_word[FIFO_TS_LSB +: pTS_WIDTH] = w_emit_ts;
    w_word[RULE_LSB +: pRULE_WIDTH]  = w_idx;
  end

  assign w_trig_evt = w_accept && I_trig_enable;
  assign w_trig_nxt = I_trig_toggle ? (r_trig ^ w_trig_evt) : w_trig_evt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (I_arm) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (I_arm)
          w_state_nxt = ST_ARMED;
        else if (I_disarm)
          w_state_nxt = (w_pend_nxt != '0) ? ST_DRAIN : ST_IDLE;
        else if (w_accept && !I_capture_mode)
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (I_arm)
          w_state_nxt = ST_ARMED;
        else if (!w_pend_any)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_ts    <= '0;
      r_t     <= '0;
      r_pend  <= '0;
      r_wr    <= 1'b0;
      r_data  <= '0;
      r_trig  <= 1'b0;
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ts    <= I_arm ? '0 : r_ts + pTS_WIDTH'(1);
      if (w_accept) r_t <= r_ts;
      r_pend  <= w_pend_nxt;
      r_wr    <= w_emit;
      if (w_emit) r_data <= w_word;
      r_trig  <= w_trig_nxt;
      r_armed <= (w_state_nxt == ST_ARMED);
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (I_arm)       r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign O_fifo_wr   = r_wr;
  assign O_fifo_data = r_data;
  assign O_trig_out  = r_trig;
  assign O_armed     = r_armed;
  assign O_busy      = r_busy;
  assign O_overflow  = r_ovf;

endmodule
